// File: rtl/uart_bus_bridge_if.sv
// Bundle of the UART byte streams and the peripheral register bus seen by the bridge.
// master: the bridge side (drives tx_*, bus_req, rd, wr, addr, wdata, busy, err).
// slave:  the environment side (UART receiver/sender, bus mux, register file).
interface uart_bus_bridge_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic        bus_gnt;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  modport master (
    input  rx_valid, rx_data, tx_ready, bus_gnt, rdata,
    output tx_en, tx_data, bus_req, rd, wr, addr, wdata, busy, err
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, bus_gnt, rdata,
    input  tx_en, tx_data, bus_req, rd, wr, addr, wdata, busy, err
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART debug initiator: decodes 'W'/'R' commands from received bytes, performs one bus access, replies via UART.
// Latency: bus request the cycle after the last command byte; access one cycle after grant; reply starts when tx_ready.
// Backpressure: waits indefinitely on bus_gnt and tx_ready; bytes arriving while busy past DATA are dropped.
// Ports: clk, reset (async, active-low), bif (master modport: rx_*, tx_*, bus_req/gnt, rd/wr, addr/wdata/rdata, busy, err).
module uart_bus_bridge #(
  parameter int TX_HOLD = 325,
  parameter int TIMEOUT = 10000000,
  parameter int CNT_W   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_bus_bridge_if.master     bif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_ACCESS, S_SEND, S_TXHOLD, S_TXWAIT
  } state_t;

  state_t             state, state_nxt;
  logic               rx_prev;
  logic               new_byte;
  logic               opcode_ok;
  logic               last_byte;
  logic               timeout;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         byte_cnt;
  logic               is_write;
  logic [31:0]        reply;
  logic [2:0]         left;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;
  logic [7:0]         tx_data_r;
  logic               err_r;

  // rx_valid is a level; only its rising edge marks a fresh byte.
  assign new_byte  = bif.rx_valid & ~rx_prev;
  assign opcode_ok = (bif.rx_data == 8'h57) || (bif.rx_data == 8'h52);
  assign last_byte = (byte_cnt == 2'd3);
  // The counter restarts on every byte, so this fires after TIMEOUT idle cycles.
  assign timeout   = ((state == S_ADDR) || (state == S_DATA)) && !new_byte &&
                     (cnt == CNT_W'(TIMEOUT - 1));

  assign bif.addr    = addr_r;
  assign bif.wdata   = wdata_r;
  assign bif.tx_data = tx_data_r;
  assign bif.err     = err_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (new_byte) state_nxt = opcode_ok ? S_ADDR : S_SEND;
      S_ADDR: begin
        if (new_byte && last_byte) state_nxt = is_write ? S_DATA : S_REQ;
        else if (timeout)          state_nxt = S_IDLE;
      end
      S_DATA: begin
        if (new_byte && last_byte) state_nxt = S_REQ;
        else if (timeout)          state_nxt = S_IDLE;
      end
      S_REQ:    if (bif.bus_gnt) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_SEND;
      S_SEND:   if (bif.tx_ready) state_nxt = S_TXHOLD;
      S_TXHOLD: if (cnt == CNT_W'(TX_HOLD - 1)) state_nxt = S_TXWAIT;
      S_TXWAIT: if (bif.tx_ready) state_nxt = (left == 3'd0) ? S_IDLE : S_SEND;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bif.tx_en   = 1'b0;
    bif.bus_req = 1'b0;
    bif.rd      = 1'b0;
    bif.wr      = 1'b0;
    bif.busy    = (state != S_IDLE);
    case (state)
      S_REQ:    bif.bus_req = 1'b1;
      S_ACCESS: begin
        bif.bus_req = 1'b1;
        bif.rd      = ~is_write;
        bif.wr      = is_write;
      end
      S_TXHOLD: bif.tx_en = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: byte capture, shared idle/hold counter, reply shifter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev   <= 1'b0;
      cnt       <= '0;
      byte_cnt  <= 2'd0;
      is_write  <= 1'b0;
      reply     <= 32'h0;
      left      <= 3'd0;
      addr_r    <= 32'h0;
      wdata_r   <= 32'h0;
      tx_data_r <= 8'h0;
      err_r     <= 1'b0;
    end else begin
      rx_prev <= bif.rx_valid;
      err_r   <= 1'b0;

      // One counter serves both the inter-byte timeout and the tx_en hold;
      // it restarts on every state change and every received byte.
      if ((state != state_nxt) || new_byte ||
          !((state == S_ADDR) || (state == S_DATA) || (state == S_TXHOLD)))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          byte_cnt <= 2'd0;
          if (new_byte) begin
            is_write <= (bif.rx_data == 8'h57);
            if (!opcode_ok) begin
              reply <= {8'h3F, 24'h0};
              left  <= 3'd1;
              err_r <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (new_byte) begin
            addr_r   <= {addr_r[23:0], bif.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
          if (timeout) err_r <= 1'b1;
        end
        S_DATA: begin
          if (new_byte) begin
            wdata_r  <= {wdata_r[23:0], bif.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
          if (timeout) err_r <= 1'b1;
        end
        S_ACCESS: begin
          reply <= is_write ? {8'h4B, 24'h0} : bif.rdata;
          left  <= is_write ? 3'd1 : 3'd4;
        end
        S_SEND: begin
          if (bif.tx_ready) begin
            tx_data_r <= reply[31:24];
            reply     <= {reply[23:0], 8'h0};
            left      <= left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: directed commands push expected bus accesses and tx bytes,
// independent monitors pop and compare when the DUT strobes rd/wr or raises tx_en.
// Runs with a shortened TIMEOUT so the abort path fits a short simulation.
module tb_uart_bus_bridge;
  localparam int TX_HOLD = 325;
  localparam int TIMEOUT = 2000;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_bus_bridge_if bif();

  uart_bus_bridge #(.TX_HOLD(TX_HOLD), .TIMEOUT(TIMEOUT), .CNT_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int errors = 0;
  int err_count = 0;
  int bus_req_cycles = 0;
  int sender_cnt = 0;
  logic tx_block = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // UART sender model: busy while tx_en is high and for 4 cycles after.
  initial begin
    bif.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset)             sender_cnt = 0;
      else if (bif.tx_en)     sender_cnt = 4;
      else if (sender_cnt > 0) sender_cnt--;
      bif.tx_ready = (sender_cnt == 0) && !tx_block;
    end
  end

  // TX monitor: byte value at tx_en rise, hold length at tx_en fall.
  initial begin
    int hold = 0;
    logic in_tx = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_tx = 1'b0;
        hold  = 0;
      end else if (bif.tx_en) begin
        if (!in_tx) begin
          in_tx = 1'b1;
          hold  = 0;
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %h, none expected", bif.tx_data);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", 32'(bif.tx_data), 32'(e));
          end
        end
        hold++;
      end else if (in_tx) begin
        in_tx = 1'b0;
        chk("tx_hold_len", 32'(hold), 32'(TX_HOLD));
      end
    end
  end

  // Bus monitor: every rd/wr strobe must match the next expected access.
  initial begin
    logic prev = 1'b0;
    bus_t e;
    forever begin
      @(negedge clk);
      if (reset && bif.bus_req) bus_req_cycles++;
      if (reset && (bif.rd || bif.wr)) begin
        chk("strobe_single_cycle", 32'(prev), 32'd0);
        chk("strobe_with_req", 32'(bif.bus_req), 32'd1);
        chk("rd_wr_exclusive", 32'(bif.rd & bif.wr), 32'd0);
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got access addr %h, none expected", bif.addr);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_wr", 32'(bif.wr), 32'(e.is_wr));
          chk("bus_addr", bif.addr, e.addr);
          if (e.is_wr) chk("bus_wdata", bif.wdata, e.wdata);
        end
      end
      prev = reset && (bif.rd || bif.wr);
    end
  end

  // err monitor: counts pulses and rejects pulses wider than one cycle.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bif.err) begin
        err_count++;
        if (prev) begin
          checks++;
          errors++;
          $display("FAIL err_pulse_width: err high two consecutive cycles, expected 1");
        end
      end
      prev = reset && bif.err;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    bif.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[31:24], 2);
      v = v << 8;
    end
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    e.is_wr = 1'b1; e.addr = a; e.wdata = d;
    exp_bus.push_back(e);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57, 2);
    send_word(a);
    send_word(d);
  endtask

  task automatic send_read(input logic [31:0] a, input logic [31:0] rv, input int op_hold);
    bus_t e;
    logic [31:0] v;
    e.is_wr = 1'b0; e.addr = a; e.wdata = 32'h0;
    exp_bus.push_back(e);
    v = rv;
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(v[31:24]);
      v = v << 8;
    end
    bif.rdata = rv;
    send_byte(8'h52, op_hold);
    send_word(a);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bif.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, bif.busy, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rq0;
    logic bad;
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    bif.bus_gnt  = 1'b1;
    bif.rdata    = 32'h0;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx_en",   32'(bif.tx_en),   32'd0);
    chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
    chk("rst_rd",      32'(bif.rd),      32'd0);
    chk("rst_wr",      32'(bif.wr),      32'd0);
    chk("rst_busy",    32'(bif.busy),    32'd0);
    chk("rst_err",     32'(bif.err),     32'd0);
    chk("rst_addr",    bif.addr,         32'd0);
    chk("rst_wdata",   bif.wdata,        32'd0);
    chk("rst_tx_data", 32'(bif.tx_data), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(bif.busy), 32'd0);

    // 1: write, reply 'K'
    send_write(32'h4000000C, 32'h000000A5);
    wait_idle("t1_idle", 3000);
    chk("t1_addr_held",  bif.addr,  32'h4000000C);
    chk("t1_wdata_held", bif.wdata, 32'h000000A5);

    // 2: read, reply 4 bytes MSB first
    send_read(32'h40000010, 32'h000000F3, 2);
    wait_idle("t2_idle", 5000);

    // 3: bad opcode
    rq0 = bus_req_cycles;
    exp_tx.push_back(8'h3F);
    send_byte(8'h41, 2);
    wait_idle("t3_idle", 3000);
    chk("t3_no_bus_req", 32'(bus_req_cycles - rq0), 32'd0);
    chk("t3_err_count",  32'(err_count),            32'd1);

    // 4: partial command then silence -> timeout abort
    send_byte(8'h57, 2);
    send_byte(8'h40, 2);
    send_byte(8'h00, 2);
    n = 0;
    while (!bif.err && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_window", 32'((n >= TIMEOUT - 10) && (n <= TIMEOUT + 10)), 32'd1);
    chk("t4_busy_after_abort", 32'(bif.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_err_count", 32'(err_count), 32'd2);
    send_read(32'h40000020, 32'hCAFEF00D, 2);
    wait_idle("t4_read_idle", 5000);

    // 5: grant withheld, long rx_valid level, sender not ready
    bif.bus_gnt = 1'b0;
    tx_block = 1'b1;
    send_read(32'h40000030, 32'h87654321, 100);
    n = 0;
    while (!bif.bus_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_req_seen", 32'(bif.bus_req), 32'd1);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!bif.bus_req || bif.rd || bif.wr) bad = 1'b1;
    end
    chk("t5_req_held_no_strobe", 32'(bad), 32'd0);
    bif.bus_gnt = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bif.tx_en) bad = 1'b1;
    end
    chk("t5_tx_en_waits", 32'(bad), 32'd0);
    chk("t5_busy_waiting", 32'(bif.busy), 32'd1);
    tx_block = 1'b0;
    wait_idle("t5_idle", 5000);

    // 6: reset during TXHOLD
    send_write(32'h40000040, 32'h11223344);
    n = 0;
    while (!bif.tx_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_tx_en_seen", 32'(bif.tx_en), 32'd1);
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_tx_en",   32'(bif.tx_en),   32'd0);
    chk("t6_rst_bus_req", 32'(bif.bus_req), 32'd0);
    chk("t6_rst_rd_wr",   32'(bif.rd | bif.wr), 32'd0);
    chk("t6_rst_busy",    32'(bif.busy),    32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_idle_after_rst", 32'(bif.busy), 32'd0);
    send_write(32'h40000044, 32'hDEADBEEF);
    wait_idle("t6_idle", 3000);
    chk("t6_addr_held", bif.addr, 32'h40000044);

    // Everything expected was observed
    chk("end_tx_queue_empty",  32'(exp_tx.size()),  32'd0);
    chk("end_bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    chk("end_err_count",       32'(err_count),      32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
